secure_boot_ctrl: RTL and testbench

Parametrised successor to the single-image boot authenticator. Walks up to NUM_SLOTS firmware slots in order, streaming each image through an external hash engine and verifier. Falls back to the next slot on length, timeout or signature failure. Sits between the boot ROM/flash port and the security agent, and gates agent enable on the first authentic slot.

---
 rtl/secure_boot_pkg.sv | 30 +++
 rtl/boot_fetch_timer.sv | 58 +++++
 rtl/secure_boot_ctrl.sv | 247 ++++++++++++++++++++++++
 tb/tb_secure_boot_ctrl.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/secure_boot_pkg.sv
// Shared types and header-layout constants for the multi-slot secure boot controller.
// Header layout depends on ANTI_ROLLBACK_EN (see secure_boot_ctrl.sv).
package secure_boot_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_HDR_REQ,
        ST_HDR_WAIT,
        ST_DATA_REQ,
        ST_DATA_WAIT,
        ST_HASH_WAIT,
        ST_VERIFY,
        ST_SLOT_FAIL,
        ST_DONE_OK,
        ST_DONE_ERR
    } boot_state_e;

    // Narrow words (< 64 bits) pack version and length into the low 32 bits.
    localparam int HDR_WIDE_MIN_DATA_W = 64;
    localparam int HDR_LEN_W_WIDE      = 32;
    localparam int HDR_LEN_W_NARROW    = 16;
    localparam int HDR_VER_LSB_WIDE    = 32;
    localparam int HDR_VER_LSB_NARROW  = 16;
    localparam int HDR_VER_W           = 16;

    function automatic int word_bytes(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/boot_fetch_timer.sv
// Single-outstanding memory fetch handshake with a per-request response timeout.
// A response that arrives after its request timed out is swallowed by the stale flag.
module boot_fetch_timer
    import secure_boot_pkg::*;
#(
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic fetch_req,
    input  logic rsp_wait,
    input  logic mem_req_ready,
    input  logic mem_rsp_valid,
    output logic mem_req_valid,
    output logic req_accepted,
    output logic rsp_hit,
    output logic timed_out
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             stale_q, stale_d;

    always_comb begin
        mem_req_valid = fetch_req;
        req_accepted  = fetch_req & mem_req_ready;
        rsp_hit       = rsp_wait & mem_rsp_valid & ~stale_q;
        timed_out     = rsp_wait & ~rsp_hit & (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

        cnt_d   = cnt_q;
        stale_d = stale_q;

        // Counting only starts once the request has been accepted.
        if (req_accepted) begin
            cnt_d = '0;
        end else if (rsp_wait && !rsp_hit && !timed_out) begin
            cnt_d = cnt_q + 1'b1;
        end

        if (timed_out) begin
            stale_d = 1'b1;
        end else if (stale_q && mem_rsp_valid) begin
            stale_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q   <= '0;
            stale_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            stale_q <= stale_d;
        end
    end

endmodule

// File: rtl/secure_boot_ctrl.sv
// Multi-slot secure boot controller: fetches, hashes and verifies firmware slots in order.
// Optional ANTI_ROLLBACK_EN adds a header version check against min_version.
module secure_boot_ctrl
    import secure_boot_pkg::*;
#(
    parameter int                DATA_W      = 32,
    parameter int                ADDR_W      = 32,
    parameter int                NUM_SLOTS   = 2,
    parameter logic [ADDR_W-1:0] SLOT_BASE   = '0,
    parameter logic [ADDR_W-1:0] SLOT_STRIDE = ADDR_W'(32'h0001_0000),
    parameter int                MAX_WORDS   = 16384,
    parameter int                TIMEOUT_CYC = 1024
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    output logic                       mem_req_valid,
    input  logic                       mem_req_ready,
    output logic [ADDR_W-1:0]          mem_req_addr,
    input  logic                       mem_rsp_valid,
    input  logic [DATA_W-1:0]          mem_rsp_data,
    output logic                       hash_init,
    output logic                       hash_valid,
    output logic [DATA_W-1:0]          hash_data,
    output logic                       hash_last,
    input  logic                       hash_done,
    output logic                       verify_start,
    output logic [$clog2(NUM_SLOTS):0] verify_slot,
    input  logic                       verify_done,
    input  logic                       verify_pass,
`ifdef ANTI_ROLLBACK_EN
    input  logic [15:0]                min_version,
    output logic [15:0]                boot_version,
`endif
    output logic                       boot_done,
    output logic                       boot_ok,
    output logic [$clog2(NUM_SLOTS):0] boot_slot,
    output logic [NUM_SLOTS-1:0]       fail_mask,
    output logic                       agent_enable
);

    localparam int                SLOT_W = $clog2(NUM_SLOTS) + 1;
    localparam logic [ADDR_W-1:0] WORD_B = ADDR_W'(word_bytes(DATA_W));

`ifdef ANTI_ROLLBACK_EN
    localparam int LEN_W   = (DATA_W >= HDR_WIDE_MIN_DATA_W) ? HDR_LEN_W_WIDE : HDR_LEN_W_NARROW;
    localparam int VER_LSB = (DATA_W >= HDR_WIDE_MIN_DATA_W) ? HDR_VER_LSB_WIDE : HDR_VER_LSB_NARROW;
`else
    localparam int LEN_W   = HDR_LEN_W_WIDE;
`endif
    localparam logic [31:0] LEN_MASK = 32'((64'd1 << LEN_W) - 64'd1);

    boot_state_e            state_q, state_d;
    logic [SLOT_W-1:0]      slot_q, slot_d;
    logic [31:0]            idx_q, idx_d;
    logic [31:0]            len_q, len_d;
    logic [NUM_SLOTS-1:0]   fail_mask_q, fail_mask_d;
    logic [SLOT_W-1:0]      boot_slot_q, boot_slot_d;

    logic                   fetch_req, rsp_wait;
    logic                   req_accepted, rsp_hit, timed_out;
    logic [31:0]            hdr_len;
    logic                   hdr_len_bad;
    logic [ADDR_W-1:0]      addr_calc;

`ifdef ANTI_ROLLBACK_EN
    logic [HDR_VER_W-1:0]   ver_q, ver_d;
    logic [HDR_VER_W-1:0]   boot_version_q, boot_version_d;
    logic [DATA_W-1:0]      hdr_shift;
    logic [HDR_VER_W-1:0]   hdr_ver;
`endif

    boot_fetch_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_fetch (
        .clk           (clk),
        .reset         (reset),
        .fetch_req     (fetch_req),
        .rsp_wait      (rsp_wait),
        .mem_req_ready (mem_req_ready),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_req_valid (mem_req_valid),
        .req_accepted  (req_accepted),
        .rsp_hit       (rsp_hit),
        .timed_out     (timed_out)
    );

    always_comb begin
        fetch_req   = (state_q == ST_HDR_REQ) || (state_q == ST_DATA_REQ);
        rsp_wait    = (state_q == ST_HDR_WAIT) || (state_q == ST_DATA_WAIT);
        addr_calc   = SLOT_BASE + ADDR_W'(slot_q) * SLOT_STRIDE + ADDR_W'(idx_q) * WORD_B;
        hdr_len     = mem_rsp_data[31:0] & LEN_MASK;
        hdr_len_bad = (hdr_len == 32'd0) || (hdr_len > 32'(MAX_WORDS));
`ifdef ANTI_ROLLBACK_EN
        hdr_shift   = mem_rsp_data >> VER_LSB;
        hdr_ver     = hdr_shift[HDR_VER_W-1:0];
`endif
    end

    always_comb begin
        state_d      = state_q;
        slot_d       = slot_q;
        idx_d        = idx_q;
        len_d        = len_q;
        fail_mask_d  = fail_mask_q;
        boot_slot_d  = boot_slot_q;
`ifdef ANTI_ROLLBACK_EN
        ver_d          = ver_q;
        boot_version_d = boot_version_q;
`endif
        hash_init    = 1'b0;
        hash_valid   = 1'b0;
        hash_data    = '0;
        hash_last    = 1'b0;
        verify_start = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d     = ST_HDR_REQ;
                    slot_d      = '0;
                    idx_d       = '0;
                    fail_mask_d = '0;
                end
            end
            ST_HDR_REQ: begin
                if (req_accepted) state_d = ST_HDR_WAIT;
            end
            ST_HDR_WAIT: begin
                if (rsp_hit) begin
                    len_d = hdr_len;
`ifdef ANTI_ROLLBACK_EN
                    ver_d = hdr_ver;
                    if (hdr_len_bad || (hdr_ver < min_version)) begin
`else
                    if (hdr_len_bad) begin
`endif
                        state_d = ST_SLOT_FAIL;
                    end else begin
                        hash_init = 1'b1;
                        idx_d     = 32'd1;
                        state_d   = ST_DATA_REQ;
                    end
                end else if (timed_out) begin
                    state_d = ST_SLOT_FAIL;
                end
            end
            ST_DATA_REQ: begin
                if (req_accepted) state_d = ST_DATA_WAIT;
            end
            ST_DATA_WAIT: begin
                // Payload is streamed straight through; the hash engine never stalls.
                if (rsp_hit) begin
                    hash_valid = 1'b1;
                    hash_data  = mem_rsp_data;
                    hash_last  = (idx_q == len_q);
                    if (idx_q == len_q) begin
                        state_d = ST_HASH_WAIT;
                    end else begin
                        idx_d   = idx_q + 32'd1;
                        state_d = ST_DATA_REQ;
                    end
                end else if (timed_out) begin
                    state_d = ST_SLOT_FAIL;
                end
            end
            ST_HASH_WAIT: begin
                if (hash_done) begin
                    verify_start = 1'b1;
                    state_d      = ST_VERIFY;
                end
            end
            ST_VERIFY: begin
                if (verify_done) begin
                    if (verify_pass) begin
                        state_d     = ST_DONE_OK;
                        boot_slot_d = slot_q;
`ifdef ANTI_ROLLBACK_EN
                        boot_version_d = ver_q;
`endif
                    end else begin
                        state_d = ST_SLOT_FAIL;
                    end
                end
            end
            ST_SLOT_FAIL: begin
                if (slot_q == SLOT_W'(NUM_SLOTS - 1)) begin
                    state_d = ST_DONE_ERR;
                end else begin
                    slot_d  = slot_q + 1'b1;
                    idx_d   = '0;
                    state_d = ST_HDR_REQ;
                end
            end
            ST_DONE_OK, ST_DONE_ERR: begin
                state_d = state_q;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if ((state_d == ST_SLOT_FAIL) && (state_q != ST_SLOT_FAIL)) begin
            fail_mask_d = fail_mask_q | (NUM_SLOTS'(1) << slot_q);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            slot_q      <= '0;
            idx_q       <= '0;
            len_q       <= '0;
            fail_mask_q <= '0;
            boot_slot_q <= '0;
`ifdef ANTI_ROLLBACK_EN
            ver_q          <= '0;
            boot_version_q <= '0;
`endif
        end else begin
            state_q     <= state_d;
            slot_q      <= slot_d;
            idx_q       <= idx_d;
            len_q       <= len_d;
            fail_mask_q <= fail_mask_d;
            boot_slot_q <= boot_slot_d;
`ifdef ANTI_ROLLBACK_EN
            ver_q          <= ver_d;
            boot_version_q <= boot_version_d;
`endif
        end
    end

    always_comb begin
        mem_req_addr = fetch_req ? addr_calc : '0;
        verify_slot  = ((state_q == ST_HASH_WAIT) || (state_q == ST_VERIFY)) ? slot_q : '0;
        boot_done    = (state_q == ST_DONE_OK) || (state_q == ST_DONE_ERR);
        boot_ok      = (state_q == ST_DONE_OK);
        boot_slot    = boot_slot_q;
        fail_mask    = fail_mask_q;
        agent_enable = (state_q == ST_DONE_OK);
`ifdef ANTI_ROLLBACK_EN
        boot_version = boot_version_q;
`endif
    end

endmodule

// File: tb/tb_secure_boot_ctrl.sv
// Directed bench for secure_boot_ctrl (2 slots, TIMEOUT_CYC=16) with a behavioural memory,
// hash engine and verifier. Build with ANTI_ROLLBACK_EN to add the version-check case.
module tb_secure_boot_ctrl;

    localparam int TO = 16;

    logic        clk;
    logic        reset;
    logic        start;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        hash_init;
    logic        hash_valid;
    logic [31:0] hash_data;
    logic        hash_last;
    logic        hash_done;
    logic        verify_start;
    logic [1:0]  verify_slot;
    logic        verify_done;
    logic        verify_pass;
    logic        boot_done;
    logic        boot_ok;
    logic [1:0]  boot_slot;
    logic [1:0]  fail_mask;
    logic        agent_enable;
`ifdef ANTI_ROLLBACK_EN
    logic [15:0] min_version;
    logic [15:0] boot_version;
`endif

    secure_boot_ctrl #(
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_addr  (mem_req_addr),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_data  (mem_rsp_data),
        .hash_init     (hash_init),
        .hash_valid    (hash_valid),
        .hash_data     (hash_data),
        .hash_last     (hash_last),
        .hash_done     (hash_done),
        .verify_start  (verify_start),
        .verify_slot   (verify_slot),
        .verify_done   (verify_done),
        .verify_pass   (verify_pass),
`ifdef ANTI_ROLLBACK_EN
        .min_version   (min_version),
        .boot_version  (boot_version),
`endif
        .boot_done     (boot_done),
        .boot_ok       (boot_ok),
        .boot_slot     (boot_slot),
        .fail_mask     (fail_mask),
        .agent_enable  (agent_enable)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk;
    int n_fail;

    // Behavioural environment state.
    int          cyc;
    int          lat;
    int          late_lat;
    logic [31:0] drop_addr;
    bit          pend, late_pend, hd_pend, vd_pend, vd_res;
    int          pend_wait, late_wait, hd_wait, vd_wait;
    logic [31:0] pend_addr, late_addr;
    int          stall_left;
    logic [31:0] hdr_tbl [2];
    bit          pass_tbl [2];

    // Observations.
    logic [31:0] req_a [$];
    logic [31:0] hw_d [$];
    bit          hw_l [$];
    int          hinit_n, vstart_n;
    logic [1:0]  vslot_last;
    int          drop_acc, fm0_tick;
    int          stall_seen;
    bit          stall_addr_ok;
    logic [31:0] stall_addr;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_read(input logic [31:0] a);
        logic [31:0] s;
        logic [31:0] idx;
        s   = a >> 16;
        idx = (a & 32'h0000_FFFF) >> 2;
        if (idx == 0) return hdr_tbl[s[0]];
        return 32'hD000_0000 | (s << 16) | idx;
    endfunction

    task automatic clear_env();
        pend = 0; late_pend = 0; hd_pend = 0; vd_pend = 0; vd_res = 0;
        pend_wait = 0; late_wait = 0; hd_wait = 0; vd_wait = 0;
        pend_addr = '0; late_addr = '0;
        lat = 1; late_lat = 1; drop_addr = 32'hFFFF_FFFF; stall_left = 0;
        req_a.delete(); hw_d.delete(); hw_l.delete();
        hinit_n = 0; vstart_n = 0; vslot_last = '0;
        drop_acc = -1; fm0_tick = -1;
        stall_seen = 0; stall_addr_ok = 1; stall_addr = '0;
    endtask

    // One clock: drive inputs after the falling edge, observe 1ns later.
    task automatic tick();
        @(negedge clk);
        mem_rsp_valid = 0; mem_rsp_data = '0;
        hash_done = 0; verify_done = 0; verify_pass = 0;
        if (late_pend) begin
            if (late_wait == 0) begin
                mem_rsp_valid = 1; mem_rsp_data = mem_read(late_addr); late_pend = 0;
            end else late_wait--;
        end
        if (pend) begin
            if (pend_wait == 0 && !mem_rsp_valid) begin
                mem_rsp_valid = 1; mem_rsp_data = mem_read(pend_addr); pend = 0;
            end else if (pend_wait > 0) pend_wait--;
        end
        if (hd_pend) begin
            if (hd_wait == 0) begin hash_done = 1; hd_pend = 0; end
            else hd_wait--;
        end
        if (vd_pend) begin
            if (vd_wait == 0) begin verify_done = 1; verify_pass = vd_res; vd_pend = 0; end
            else vd_wait--;
        end
        mem_req_ready = (stall_left == 0);
        #1;
        if (mem_req_valid && !mem_req_ready) begin
            if (stall_seen == 0) stall_addr = mem_req_addr;
            else if (mem_req_addr != stall_addr) stall_addr_ok = 0;
            stall_seen++;
            stall_left--;
        end
        if (mem_req_valid && mem_req_ready && !reset) begin
            req_a.push_back(mem_req_addr);
            if (mem_req_addr == drop_addr) begin
                late_pend = 1; late_addr = mem_req_addr; late_wait = late_lat - 1; drop_acc = cyc;
            end else begin
                pend = 1; pend_addr = mem_req_addr; pend_wait = lat - 1;
            end
        end
        if (hash_valid) begin
            hw_d.push_back(hash_data);
            hw_l.push_back(hash_last);
            if (hash_last) begin hd_pend = 1; hd_wait = 1; end
        end
        if (hash_init) hinit_n++;
        if (verify_start) begin
            vstart_n++; vslot_last = verify_slot;
            vd_pend = 1; vd_wait = 1; vd_res = pass_tbl[verify_slot[0]];
        end
        if (fail_mask[0] && fm0_tick < 0) fm0_tick = cyc;
        cyc++;
    endtask

    task automatic reset_dut();
        reset = 1; start = 0;
        tick(); tick();
        reset = 0;
        clear_env();
    endtask

    task automatic run_boot(input string tag, input int budget);
        int n;
        n = 0;
        start = 1;
        tick();
        start = 0;
        while (!boot_done && n < budget) begin
            tick();
            n++;
        end
        check_eq({tag, "_finished"}, boot_done, 1'b1);
    endtask

    initial begin
        n_chk = 0; n_fail = 0; cyc = 0;
        reset = 1; start = 0; mem_req_ready = 0; mem_rsp_valid = 0; mem_rsp_data = '0;
        hash_done = 0; verify_done = 0; verify_pass = 0;
`ifdef ANTI_ROLLBACK_EN
        min_version = 16'd0;
`endif
        hdr_tbl[0] = 32'd4; hdr_tbl[1] = 32'd2;
        pass_tbl[0] = 1; pass_tbl[1] = 1;
        clear_env();

        // Reset state.
        reset_dut();
        tick();
        check_eq("rst_boot_done", boot_done, 1'b0);
        check_eq("rst_boot_ok", boot_ok, 1'b0);
        check_eq("rst_boot_slot", boot_slot, 2'd0);
        check_eq("rst_fail_mask", fail_mask, 2'b00);
        check_eq("rst_agent", agent_enable, 1'b0);
        check_eq("rst_req_valid", mem_req_valid, 1'b0);
        check_eq("rst_req_addr", mem_req_addr, 32'h0);
        check_eq("rst_hash_valid", hash_valid, 1'b0);

        // Slot 0 authentic, N=4.
        run_boot("ok0", 200);
        check_eq("ok0_req_n", req_a.size(), 5);
        for (int i = 0; i < 5; i++)
            if (i < req_a.size()) check_eq($sformatf("ok0_addr%0d", i), req_a[i], 32'(i * 4));
        check_eq("ok0_hash_n", hw_d.size(), 4);
        for (int i = 0; i < 4; i++)
            if (i < hw_d.size()) begin
                check_eq($sformatf("ok0_hdata%0d", i), hw_d[i], 32'hD000_0001 + 32'(i));
                check_eq($sformatf("ok0_hlast%0d", i), hw_l[i], (i == 3));
            end
        check_eq("ok0_hinit", hinit_n, 1);
        check_eq("ok0_vslot", vslot_last, 2'd0);
        check_eq("ok0_boot_ok", boot_ok, 1'b1);
        check_eq("ok0_boot_slot", boot_slot, 2'd0);
        check_eq("ok0_fail_mask", fail_mask, 2'b00);
        check_eq("ok0_agent", agent_enable, 1'b1);
        // Done is sticky; a new start must be ignored.
        start = 1; tick(); start = 0;
        for (int i = 0; i < 5; i++) tick();
        check_eq("ok0_sticky_req_n", req_a.size(), 5);
        check_eq("ok0_sticky_ok", boot_ok, 1'b1);

        // Slot 0 signature bad, slot 1 N=2 good.
        reset_dut();
        pass_tbl[0] = 0; pass_tbl[1] = 1;
        run_boot("fb1", 300);
        check_eq("fb1_req_n", req_a.size(), 8);
        if (req_a.size() == 8) begin
            check_eq("fb1_addr5", req_a[5], 32'h0001_0000);
            check_eq("fb1_addr7", req_a[7], 32'h0001_0008);
        end
        check_eq("fb1_hash_n", hw_d.size(), 6);
        check_eq("fb1_hinit", hinit_n, 2);
        check_eq("fb1_vslot", vslot_last, 2'd1);
        check_eq("fb1_boot_slot", boot_slot, 2'd1);
        check_eq("fb1_fail_mask", fail_mask, 2'b01);
        check_eq("fb1_agent", agent_enable, 1'b1);

        // Bad lengths in both slots.
        reset_dut();
        hdr_tbl[0] = 32'd0; hdr_tbl[1] = 32'd16385;
        pass_tbl[0] = 1; pass_tbl[1] = 1;
        run_boot("err", 200);
        check_eq("err_req_n", req_a.size(), 2);
        check_eq("err_hash_n", hw_d.size(), 0);
        check_eq("err_hinit", hinit_n, 0);
        check_eq("err_boot_ok", boot_ok, 1'b0);
        check_eq("err_boot_slot", boot_slot, 2'd0);
        check_eq("err_fail_mask", fail_mask, 2'b11);
        check_eq("err_agent", agent_enable, 1'b0);

        // Slot 0 word 3 never answers in time; its late response lands in slot 1 HDR_WAIT.
        reset_dut();
        hdr_tbl[0] = 32'd4; hdr_tbl[1] = 32'd2;
        lat = 2; drop_addr = 32'h0000_000C; late_lat = TO + 3;
        run_boot("to", 400);
        check_eq("to_fail_delay", fm0_tick - drop_acc, TO + 1);
        check_eq("to_boot_ok", boot_ok, 1'b1);
        check_eq("to_boot_slot", boot_slot, 2'd1);
        check_eq("to_fail_mask", fail_mask, 2'b01);
        check_eq("to_hash_n", hw_d.size(), 4);
        for (int i = 0; i < hw_d.size(); i++)
            check_eq($sformatf("to_no_late%0d", i), (hw_d[i] == 32'hD000_0003), 1'b0);

        // Ready held low for 5 cycles on the header, slow responses just under the timeout.
        reset_dut();
        stall_left = 5; lat = TO - 1;
        run_boot("stall", 400);
        check_eq("stall_cycles", stall_seen, 5);
        check_eq("stall_addr_stable", stall_addr_ok, 1'b1);
        check_eq("stall_addr", stall_addr, 32'h0);
        check_eq("stall_boot_ok", boot_ok, 1'b1);
        check_eq("stall_fail_mask", fail_mask, 2'b00);

        // Reset while waiting on slot 1 payload, then restart.
        reset_dut();
        pass_tbl[0] = 0; pass_tbl[1] = 1; lat = 3;
        start = 1; tick(); start = 0;
        for (int n = 0; n < 300; n++) begin
            if (req_a.size() > 0 && req_a[req_a.size()-1] == 32'h0001_0004) break;
            tick();
        end
        check_eq("rm_reached", req_a.size() > 0 && req_a[req_a.size()-1] == 32'h0001_0004, 1'b1);
        tick();
        reset = 1;
        tick();
        check_eq("rm_boot_done", boot_done, 1'b0);
        check_eq("rm_fail_mask", fail_mask, 2'b00);
        check_eq("rm_req_valid", mem_req_valid, 1'b0);
        tick();
        check_eq("rm_hash_valid_rst", hash_valid, 1'b0);
        reset = 0;
        tick();
        check_eq("rm_hash_valid_idle", hash_valid, 1'b0);
        check_eq("rm_vslot", verify_slot, 2'd0);
        clear_env();
        pass_tbl[0] = 1; pass_tbl[1] = 1;
        run_boot("rm", 200);
        check_eq("rm_first_addr", req_a.size() > 0 ? req_a[0] : 32'hFFFF_FFFF, 32'h0);
        check_eq("rm_boot_slot", boot_slot, 2'd0);
        check_eq("rm_fail_mask2", fail_mask, 2'b00);

`ifdef ANTI_ROLLBACK_EN
        // Slot 0 version 3 below minimum 4; slot 1 version 5 accepted.
        reset_dut();
        min_version = 16'd4;
        hdr_tbl[0] = 32'h0003_0004; hdr_tbl[1] = 32'h0005_0002;
        run_boot("arb", 200);
        check_eq("arb_req_n", req_a.size(), 4);
        check_eq("arb_hinit", hinit_n, 1);
        check_eq("arb_fail_mask", fail_mask, 2'b01);
        check_eq("arb_boot_slot", boot_slot, 2'd1);
        check_eq("arb_version", boot_version, 16'd5);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
